// File: rtl/rob_pkg.sv
// Shared constants and types for the reorder-buffer pointer/status controller.
package rob_pkg;

  localparam int ROB_DEPTH = 64;
  localparam int IDX_W     = 6;
  localparam int WB_PORTS  = 2;

  typedef logic [IDX_W-1:0] rob_idx_t;
  typedef logic [IDX_W:0]   rob_cnt_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } rob_ctrl_state_e;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping ROB pointer: advances by 0, 1 or 2 entries per cycle and can be
// cleared back to entry 0. Used for both head and tail of the ROB.
module rob_ptr
  import rob_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [1:0]       inc,
  output logic [IDX_W-1:0] ptr
);

  // Pointer register; wrap-around falls out of the IDX_W-bit addition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else begin
      ptr <= ptr + rob_idx_t'(inc);
    end
  end

endmodule

// File: rtl/rob_commit_ctrl.sv
// Reorder-buffer pointer/status controller: hands out ROB indices to rename,
// records writeback completion, retires up to two oldest completed entries per
// cycle in order, and discards everything on flush.
// Optional feature macro: ROB_PERF_EN adds saturating commit / full-stall counters.
module rob_commit_ctrl
  import rob_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_valid,
  output logic                      alloc_ready,
  output logic [IDX_W-1:0]          alloc_idx,
  input  logic [WB_PORTS-1:0]       wb_valid,
  input  logic [WB_PORTS*IDX_W-1:0] wb_idx,
  input  logic                      commit_ready,
  output logic [1:0]                commit_valid,
  output logic [IDX_W-1:0]          commit_idx0,
  output logic [IDX_W-1:0]          commit_idx1,
  input  logic                      flush,
  output logic [IDX_W:0]            rob_count,
  output logic                      rob_empty
`ifdef ROB_PERF_EN
  ,
  output logic [31:0]               perf_commit_cnt,
  output logic [31:0]               perf_full_cyc
`endif
);

  localparam rob_cnt_t FULL_CNT = rob_cnt_t'(ROB_DEPTH);

  rob_ctrl_state_e      state, state_next;
  rob_cnt_t             count;
  rob_idx_t             head, tail, head_p1;
  logic [ROB_DEPTH-1:0] valid, done;
  logic [ROB_DEPTH-1:0] alloc_mask, wb_set, commit_clr;
  logic                 alloc_fire;
  logic [1:0]           commit_num;

  assign head_p1    = head + rob_idx_t'(1);
  assign alloc_fire = alloc_valid && alloc_ready;
  assign commit_num = {1'b0, commit_valid[0]} + {1'b0, commit_valid[1]};

  assign alloc_idx   = tail;
  assign commit_idx0 = head;
  assign commit_idx1 = head_p1;
  assign rob_count   = count;
  assign rob_empty   = (count == '0);

  // Run/flush state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Next state plus grant/commit decisions; a flush arriving in RUN already blocks both.
  always_comb begin
    state_next   = state;
    alloc_ready  = 1'b0;
    commit_valid = 2'b00;
    case (state)
      RUN: begin
        if (flush) begin
          state_next = FLUSH;
        end else begin
          alloc_ready = (count < FULL_CNT);
          if (commit_ready && (count >= rob_cnt_t'(1)) && done[head]) begin
            commit_valid[0] = 1'b1;
            if ((count >= rob_cnt_t'(2)) && done[head_p1]) commit_valid[1] = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (!flush) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // Per-entry update masks for this edge: new allocation, completions, retirements.
  always_comb begin
    alloc_mask = '0;
    wb_set     = '0;
    commit_clr = '0;
    alloc_mask[tail] = alloc_fire;
    if (state == RUN && !flush) begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && valid[wb_idx[p*IDX_W +: IDX_W]]) wb_set[wb_idx[p*IDX_W +: IDX_W]] = 1'b1;
      end
    end
    commit_clr[head]    = commit_valid[0];
    commit_clr[head_p1] = commit_valid[1];
  end

  // Valid/done bits; a retiring entry's clear wins over a same-edge writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      done  <= '0;
    end else if (flush) begin
      valid <= '0;
      done  <= '0;
    end else begin
      valid <= (valid & ~commit_clr) | alloc_mask;
      done  <= (done | wb_set) & ~commit_clr & ~alloc_mask;
    end
  end

  // Occupancy counter: +1 per grant, minus the number retired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        count <= '0;
    else if (flush) count <= '0;
    else            count <= count + rob_cnt_t'(alloc_fire) - rob_cnt_t'(commit_num);
  end

  rob_ptr u_head (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (commit_num),
    .ptr (head)
  );

  rob_ptr u_tail (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc ({1'b0, alloc_fire}),
    .ptr (tail)
  );

`ifdef ROB_PERF_EN
  logic [32:0] perf_commit_sum;
  assign perf_commit_sum = {1'b0, perf_commit_cnt} + 33'(commit_num);

  // Saturating performance counters; only reset clears them, flush does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_commit_cnt <= '0;
      perf_full_cyc   <= '0;
    end else begin
      perf_commit_cnt <= perf_commit_sum[32] ? 32'hFFFF_FFFF : perf_commit_sum[31:0];
      if ((count == FULL_CNT) && alloc_valid && (perf_full_cyc != 32'hFFFF_FFFF))
        perf_full_cyc <= perf_full_cyc + 32'd1;
    end
  end
`endif

  a_count_le_depth : assert property (@(posedge clk) disable iff (rst) count <= FULL_CNT);
  a_count_matches_ptrs : assert property (@(posedge clk) disable iff (rst)
    count[IDX_W-1:0] == rob_idx_t'(tail - head));

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: a queue-based ROB model is compared
// against the DUT every cycle, directed scenarios pin known values, and a
// randomized phase exercises fill/drain/flush/reset mixes.
module tb_rob_commit_ctrl;
  import rob_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      alloc_valid = 1'b0;
  logic                      alloc_ready;
  logic [IDX_W-1:0]          alloc_idx;
  logic [WB_PORTS-1:0]       wb_valid = '0;
  logic [WB_PORTS*IDX_W-1:0] wb_idx = '0;
  logic                      commit_ready = 1'b0;
  logic [1:0]                commit_valid;
  logic [IDX_W-1:0]          commit_idx0, commit_idx1;
  logic                      flush = 1'b0;
  logic [IDX_W:0]            rob_count;
  logic                      rob_empty;
`ifdef ROB_PERF_EN
  logic [31:0]               perf_commit_cnt, perf_full_cyc;
`endif

  rob_commit_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_ready  (alloc_ready),
    .alloc_idx    (alloc_idx),
    .wb_valid     (wb_valid),
    .wb_idx       (wb_idx),
    .commit_ready (commit_ready),
    .commit_valid (commit_valid),
    .commit_idx0  (commit_idx0),
    .commit_idx1  (commit_idx1),
    .flush        (flush),
    .rob_count    (rob_count),
    .rob_empty    (rob_empty)
`ifdef ROB_PERF_EN
    ,
    .perf_commit_cnt (perf_commit_cnt),
    .perf_full_cyc   (perf_full_cyc)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: in-flight entries oldest first, plus head/tail indices.
  typedef struct {
    int idx;
    bit done;
  } ent_t;

  ent_t q[$];
  int   m_head = 0;
  int   m_tail = 0;
  bit   m_fl   = 1'b0;
  bit   e_ready;
  bit [1:0] e_cv;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    q.delete();
    m_head = 0;
    m_tail = 0;
    m_fl   = 1'b0;
  endfunction

  function automatic void modelStep();
    int n;
    int widx;
    if (flush) begin
      q.delete();
      m_head = 0;
      m_tail = 0;
      m_fl   = 1'b1;
      return;
    end
    n = int'(e_cv[0]) + int'(e_cv[1]);
    for (int k = 0; k < n; k++) void'(q.pop_front());
    m_head = (m_head + n) % ROB_DEPTH;
    if (!m_fl) begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p]) begin
          widx = int'(wb_idx[p*IDX_W +: IDX_W]);
          foreach (q[i]) if (q[i].idx == widx) q[i].done = 1'b1;
        end
      end
    end
    if (alloc_valid && e_ready) begin
      q.push_back('{idx: m_tail, done: 1'b0});
      m_tail = (m_tail + 1) % ROB_DEPTH;
    end
    m_fl = 1'b0;
  endfunction

  // Compare process: check DUT outputs mid-cycle against the model, then advance the model at the edge.
  always begin : compare_proc
    int e_count;
    bit e_run;
    @(negedge clk);
    #2;
    if (rst) modelReset();
    e_count = q.size();
    e_run   = !m_fl && !flush;
    e_ready = e_run && (e_count < ROB_DEPTH);
    e_cv    = 2'b00;
    if (e_run && commit_ready && e_count >= 1 && q[0].done) begin
      e_cv[0] = 1'b1;
      if (e_count >= 2 && q[1].done) e_cv[1] = 1'b1;
    end
    checkOutput("model_rob_count", 64'(rob_count), 64'(e_count));
    checkOutput("model_rob_empty", 64'(rob_empty), 64'(e_count == 0));
    checkOutput("model_alloc_ready", 64'(alloc_ready), 64'(e_ready));
    checkOutput("model_alloc_idx", 64'(alloc_idx), 64'(m_tail));
    checkOutput("model_commit_idx0", 64'(commit_idx0), 64'(m_head));
    checkOutput("model_commit_idx1", 64'(commit_idx1), 64'((m_head + 1) % ROB_DEPTH));
    if (!flush || m_fl) checkOutput("model_commit_valid", 64'(commit_valid), 64'(e_cv));
    @(posedge clk);
    if (rst) modelReset();
    else     modelStep();
  end

  task automatic applyStimulus(input bit av, input bit [1:0] wv, input int i0, input int i1,
                               input bit cr, input bit fl);
    @(negedge clk);
    alloc_valid  = av;
    wb_valid     = wv;
    wb_idx       = {rob_idx_t'(i1), rob_idx_t'(i0)};
    commit_ready = cr;
    flush        = fl;
  endtask

  task automatic pulseReset();
    applyStimulus(0, 2'b00, 0, 0, 1, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic randomPhase(input int ap, input int cp, input int wp, input int fp, input int cycles);
    bit [1:0] wv;
    int       ix [2];
    bit       fl;
    for (int c = 0; c < cycles; c++) begin
      for (int p = 0; p < 2; p++) begin
        wv[p] = ($urandom_range(0, 99) < wp);
        if (q.size() > 0 && $urandom_range(0, 3) != 0) ix[p] = q[$urandom_range(0, q.size() - 1)].idx;
        else ix[p] = $urandom_range(0, ROB_DEPTH - 1);
      end
      fl = ($urandom_range(0, 999) < fp * 10);
      applyStimulus($urandom_range(0, 99) < ap, wv, ix[0], ix[1], $urandom_range(0, 99) < cp, fl);
      rst = ($urandom_range(0, 399) == 0);
    end
    rst = 1'b0;
  endtask

  initial begin : stimulus
    // Release reset and verify reset values.
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset_count", 64'(rob_count), 64'd0);
    checkOutput("reset_empty", 64'(rob_empty), 64'd1);
    checkOutput("reset_alloc_ready", 64'(alloc_ready), 64'd1);
    rst = 1'b0;

    // Fill: 64 grants with consecutive indices, then the 65th request is refused.
    for (int i = 0; i < ROB_DEPTH; i++) begin
      applyStimulus(1, 2'b00, 0, 0, 1, 0);
      #1;
      checkOutput("fill_alloc_idx", 64'(alloc_idx), 64'(i));
      checkOutput("fill_alloc_ready", 64'(alloc_ready), 64'd1);
    end
    applyStimulus(1, 2'b00, 0, 0, 1, 0);
    #1;
    checkOutput("full_alloc_ready", 64'(alloc_ready), 64'd0);
    checkOutput("full_count", 64'(rob_count), 64'd64);

    // Backpressure while full: complete everything with commit_ready low.
    for (int i = 0; i < ROB_DEPTH / 2; i++) applyStimulus(0, 2'b11, 2 * i, 2 * i + 1, 0, 0);
    applyStimulus(0, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("bp_commit_valid", 64'(commit_valid), 64'd0);
    checkOutput("bp_alloc_ready", 64'(alloc_ready), 64'd0);
    checkOutput("bp_count", 64'(rob_count), 64'd64);
    applyStimulus(1, 2'b00, 0, 0, 1, 0);
    #1;
    checkOutput("bp_release_commit", 64'(commit_valid), 64'd3);
    checkOutput("bp_release_alloc_ready", 64'(alloc_ready), 64'd0);
    applyStimulus(0, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("bp_after_count", 64'(rob_count), 64'd62);
    checkOutput("bp_after_alloc_ready", 64'(alloc_ready), 64'd1);

    // Reset asserted mid-traffic takes effect immediately.
    @(negedge clk);
    alloc_valid  = 1'b1;
    commit_ready = 1'b1;
    rst          = 1'b1;
    #1;
    checkOutput("midrst_count", 64'(rob_count), 64'd0);
    checkOutput("midrst_alloc_ready", 64'(alloc_ready), 64'd1);
    checkOutput("midrst_commit_valid", 64'(commit_valid), 64'd0);
    checkOutput("midrst_alloc_idx", 64'(alloc_idx), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    alloc_valid = 1'b0;

    // Dual commit ordering: slot 0 gates slot 1.
    for (int i = 0; i < 4; i++) applyStimulus(1, 2'b00, 0, 0, 1, 0);
    applyStimulus(0, 2'b01, 1, 0, 1, 0);
    applyStimulus(0, 2'b01, 0, 0, 1, 0);
    #1;
    checkOutput("dual_wait_head", 64'(commit_valid), 64'd0);
    applyStimulus(0, 2'b01, 2, 0, 1, 0);
    #1;
    checkOutput("dual_both", 64'(commit_valid), 64'd3);
    checkOutput("dual_idx0", 64'(commit_idx0), 64'd0);
    checkOutput("dual_idx1", 64'(commit_idx1), 64'd1);
    applyStimulus(0, 2'b00, 0, 0, 1, 0);
    #1;
    checkOutput("dual_single", 64'(commit_valid), 64'd1);
    checkOutput("dual_single_idx0", 64'(commit_idx0), 64'd2);
    applyStimulus(0, 2'b01, 3, 0, 1, 0);
    applyStimulus(0, 2'b00, 0, 0, 1, 0);
    applyStimulus(0, 2'b00, 0, 0, 1, 0);
    #1;
    checkOutput("dual_drained", 64'(rob_count), 64'd0);

    // Wrap-around: walk head/tail to 62, then straddle the 63->0 boundary.
    pulseReset();
    for (int k = 0; k < 62; k++) applyStimulus(1, (k > 0) ? 2'b01 : 2'b00, k - 1, 0, 1, 0);
    applyStimulus(0, 2'b01, 61, 0, 1, 0);
    applyStimulus(0, 2'b00, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 2'b00, 0, 0, 1, 0);
      #1;
      checkOutput("wrap_alloc_idx", 64'(alloc_idx), 64'((62 + k) % 64));
    end
    applyStimulus(0, 2'b11, 62, 63, 1, 0);
    applyStimulus(0, 2'b11, 0, 1, 1, 0);
    #1;
    checkOutput("wrap_commit_a", 64'(commit_valid), 64'd3);
    checkOutput("wrap_idx0_a", 64'(commit_idx0), 64'd62);
    checkOutput("wrap_idx1_a", 64'(commit_idx1), 64'd63);
    applyStimulus(0, 2'b00, 0, 0, 1, 0);
    #1;
    checkOutput("wrap_commit_b", 64'(commit_valid), 64'd3);
    checkOutput("wrap_idx0_b", 64'(commit_idx0), 64'd0);
    checkOutput("wrap_idx1_b", 64'(commit_idx1), 64'd1);
    applyStimulus(0, 2'b00, 0, 0, 1, 0);
    #1;
    checkOutput("wrap_count", 64'(rob_count), 64'd0);
    checkOutput("wrap_empty", 64'(rob_empty), 64'd1);

    // Flush held two cycles with alloc/wb active.
    pulseReset();
    for (int i = 0; i < 10; i++) applyStimulus(1, 2'b00, 0, 0, 1, 0);
    applyStimulus(1, 2'b11, 0, 1, 1, 1);
    #1;
    checkOutput("flush1_alloc_ready", 64'(alloc_ready), 64'd0);
    applyStimulus(1, 2'b11, 2, 3, 1, 1);
    #1;
    checkOutput("flush2_count", 64'(rob_count), 64'd0);
    checkOutput("flush2_alloc_ready", 64'(alloc_ready), 64'd0);
    applyStimulus(1, 2'b01, 4, 0, 1, 0);
    #1;
    checkOutput("flush_drop_alloc_ready", 64'(alloc_ready), 64'd0);
    applyStimulus(1, 2'b00, 0, 0, 1, 0);
    #1;
    checkOutput("post_flush_alloc_ready", 64'(alloc_ready), 64'd1);
    checkOutput("post_flush_alloc_idx", 64'(alloc_idx), 64'd0);
    applyStimulus(0, 2'b11, 5, 3, 1, 0);
    applyStimulus(0, 2'b00, 0, 0, 1, 0);
    #1;
    checkOutput("stale_wb_ignored", 64'(commit_valid), 64'd0);
    checkOutput("stale_wb_count", 64'(rob_count), 64'd1);
    applyStimulus(0, 2'b01, 0, 0, 1, 0);
    applyStimulus(0, 2'b00, 0, 0, 1, 0);

    // Randomized phases: filling, draining, mixed with flushes and resets.
    randomPhase(90, 20, 40, 0, 400);
    randomPhase(40, 95, 80, 0, 400);
    randomPhase(75, 60, 60, 3, 500);
    randomPhase(95, 5, 90, 0, 300);
    randomPhase(60, 80, 50, 5, 500);
    randomPhase(50, 50, 50, 1, 400);
    applyStimulus(0, 2'b00, 0, 0, 1, 0);
    applyStimulus(0, 2'b00, 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
